chain_stage_fifo: RTL and testbench



---
 rtl/chain_stage_pkg.sv | 19 +
 rtl/chain_stage_mem.sv | 25 ++
 rtl/chain_stage_fifo.sv | 98 +++++++++
 tb/tb_chain_stage_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_stage_pkg.sv
// Shared types and constants for the chain forwarding stage: hop counter and
// statistics counter types, with saturating increment helpers.
package chain_stage_pkg;

   typedef logic [7:0]  hop_t;
   typedef logic [15:0] stat_cnt_t;

   localparam hop_t      HOP_MAX  = 8'hFF;
   localparam stat_cnt_t STAT_MAX = 16'hFFFF;

   function automatic hop_t hop_inc(input hop_t h);
      return (h == HOP_MAX) ? HOP_MAX : hop_t'(h + 8'd1);
   endfunction

   function automatic stat_cnt_t stat_inc(input stat_cnt_t c);
      return (c == STAT_MAX) ? STAT_MAX : stat_cnt_t'(c + 16'd1);
   endfunction

endpackage

// File: rtl/chain_stage_mem.sv
// Register-array storage for the chain stage FIFO: one synchronous write port
// and one asynchronous read port.
module chain_stage_mem #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; occupancy tracking guarantees no entry is read
   // before it is written, so resetting the array would only cost flops.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/chain_stage_fifo.sv
// Buffered forwarding stage: queues upstream tokens, stamps a saturating hop
// count and presents them downstream. Define CHAIN_STAGE_STATS_EN for counters.
module chain_stage_fifo
   import chain_stage_pkg::*;
#(
   parameter int         DATA_W   = 16,
   parameter int         DEPTH    = 4,
   parameter logic [7:0] STAGE_ID = 8'd0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  hop_t                     in_hops,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output hop_t                     out_hops,
   output logic [7:0]               out_last_id,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     hop_sat
`ifdef CHAIN_STAGE_STATS_EN
   ,
   output stat_cnt_t                stall_cnt,
   output stat_cnt_t                xfer_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int MW = DATA_W + 8;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          hop_sat_q;
   logic          push;
   logic          pop;
   logic [MW-1:0] rd_word;

   // Handshakes depend only on occupancy, so no ready path crosses the stage.
   assign in_ready    = (count_q != CW'(DEPTH));
   assign out_valid   = (count_q != '0);
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign count       = count_q;
   assign hop_sat     = hop_sat_q;
   assign out_last_id = STAGE_ID;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         hop_sat_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (push && (in_hops == HOP_MAX)) hop_sat_q <= 1'b1;
      end
   end

   chain_stage_mem #(
      .WIDTH (MW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data ({in_data, hop_inc(in_hops)}),
      .rd_addr (rd_ptr),
      .rd_data (rd_word)
   );

   assign out_data = rd_word[MW-1:8];
   assign out_hops = rd_word[7:0];

`ifdef CHAIN_STAGE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         xfer_cnt  <= '0;
      end else begin
         if (out_valid && !out_ready) stall_cnt <= stat_inc(stall_cnt);
         if (pop)                     xfer_cnt  <= stat_inc(xfer_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_chain_stage_fifo.sv
// Self-checking bench for chain_stage_fifo: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_chain_stage_fifo;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam logic [7:0] STAGE_ID = 8'h5A;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_data;
   logic [7:0]             in_hops;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic [7:0]             out_hops;
   logic [7:0]             out_last_id;
   logic [$clog2(DEPTH):0] count;
   logic                   hop_sat;
`ifdef CHAIN_STAGE_STATS_EN
   logic [15:0]            stall_cnt;
   logic [15:0]            xfer_cnt;
`endif

   chain_stage_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .STAGE_ID (STAGE_ID)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_hops     (in_hops),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_hops    (out_hops),
      .out_last_id (out_last_id),
      .count       (count),
      .hop_sat     (hop_sat)
`ifdef CHAIN_STAGE_STATS_EN
      ,
      .stall_cnt   (stall_cnt),
      .xfer_cnt    (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: an ordered queue of tokens plus the sticky flag.
   typedef struct {
      logic [DATA_W-1:0] data;
      int                hops;
   } tok_t;

   tok_t q[$];
   bit   m_sat     = 0;
   bit   started   = 0;
   int   m_stall   = 0;
   int   m_xfer    = 0;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_sat   = 0;
         m_stall = 0;
         m_xfer  = 0;
         started = 1;
      end else if (started) begin
         bit   do_push;
         bit   do_pop;
         tok_t t;
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = out_ready && (q.size() > 0);
         if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
         if (do_pop && m_xfer < 65535) m_xfer++;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            t.data = in_data;
            t.hops = int'(in_hops) + 1;
            if (t.hops > 255) t.hops = 255;
            q.push_back(t);
            if (in_hops == 8'd255) m_sat = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (started && !rst) begin
         check("in_ready",    32'(in_ready),  32'(q.size() != DEPTH));
         check("out_valid",   32'(out_valid), 32'(q.size() != 0));
         check("count",       32'(count),     32'(q.size()));
         check("hop_sat",     32'(hop_sat),   32'(m_sat));
         check("out_last_id", 32'(out_last_id), 32'(8'h5A));
         if (q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(q[0].data));
            check("out_hops", 32'(out_hops), 32'(q[0].hops));
         end
`ifdef CHAIN_STAGE_STATS_EN
         check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         check("xfer_cnt",  32'(xfer_cnt),  32'(m_xfer));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [7:0] h, input logic r);
      in_valid  = v;
      in_data   = d;
      in_hops   = h;
      out_ready = r;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 8'd0, 1'b0);
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_hop_sat",   32'(hop_sat),   32'd0);

      // Fill with 1..5 while blocked, then drain in order
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, DATA_W'(i), 8'd7, 1'b0);
         tick();
      end
      check("full_count",    32'(count),    32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b0, 'x, 8'd0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", 32'(out_valid), 32'd1);
         check("drain_data",  32'(out_data),  32'(i));
         check("drain_hops",  32'(out_hops),  32'd8);
         tick();
      end
      check("drained_valid", 32'(out_valid), 32'd0);

      // Streaming: one token per cycle at occupancy 1
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, DATA_W'($urandom), 8'd3, 1'b1);
         tick();
         check("stream_count", 32'(count),    32'd1);
         check("stream_hops",  32'(out_hops), 32'd4);
      end
      drive(1'b0, '0, 8'd0, 1'b1);
      tick();

      // Hop saturation and sticky flag
      drive(1'b1, 16'hBEEF, 8'd255, 1'b0);
      tick();
      check("sat_hops", 32'(out_hops), 32'd255);
      check("sat_flag", 32'(hop_sat),  32'd1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, DATA_W'(i), 8'd0, 1'b1);
         tick();
         check("sat_sticky", 32'(hop_sat), 32'd1);
      end
      drive(1'b0, '0, 8'd0, 1'b1);
      tick();

      // Both handshakes at full: only the pop happens, then occupancy holds
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, DATA_W'(16'h100 + i), 8'd1, 1'b0);
         tick();
      end
      for (int i = 0; i < 3 * DEPTH; i++) begin
         drive(1'b1, DATA_W'(16'h200 + i), 8'd1, 1'b1);
         tick();
         check("fullsim_count", 32'(count), 32'd3);
      end
      // Mid occupancy: drain to 2, then push and pop together
      drive(1'b0, '0, 8'd0, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, DATA_W'(16'h300 + i), 8'd2, 1'b1);
         tick();
         check("midsim_count", 32'(count), 32'd2);
      end

      // Reset mid-operation at count 3, with push and pop requested
      drive(1'b1, 16'h0400, 8'd2, 1'b0);
      tick();
      check("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1;
      drive(1'b1, 16'h0401, 8'd2, 1'b1);
      tick();
      rst = 1'b0;
      drive(1'b0, '0, 8'd0, 1'b0);
      check("post_rst_count", 32'(count),     32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef CHAIN_STAGE_STATS_EN
      drive(1'b1, 16'h0500, 8'd0, 1'b0);
      tick();
      drive(1'b0, '0, 8'd0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      check("stall_cnt_10", 32'(stall_cnt), 32'd10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("stall_cnt_rst", 32'(stall_cnt), 32'd0);
`endif

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 9);
         drive($urandom_range(0, 3) != 0, DATA_W'($urandom),
               (r == 0) ? 8'd255 : (r == 1) ? 8'd254 : 8'($urandom_range(0, 250)),
               $urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
